assign_enum_driver: RTL and testbench

ASSIGN_ENUM_DRIVER -- requirements
Module: assign_enum_driver

---
 rtl/assign_enum_driver_pkg.sv | 14 +
 rtl/assign_enum_driver.sv | 141 ++++++++++++++
 tb/tb_assign_enum_driver.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/assign_enum_driver_pkg.sv
// Shared types and defaults for the exhaustive assignment enumerator.
package assign_enum_driver_pkg;

    localparam int NUM_VARS_DEF = 49;
    localparam int CNT_W_DEF    = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/assign_enum_driver.sv
// Walks consecutive assignments from a base into a formula evaluator, one outstanding
// at a time, counting verdicts and latching the first counterexample.
module assign_enum_driver
    import assign_enum_driver_pkg::*;
#(
    parameter int NUM_VARS = NUM_VARS_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_VARS-1:0] base,
    input  logic [CNT_W-1:0]    limit,
    input  logic                stop_on_cex,
    output logic [NUM_VARS-1:0] asg,
    output logic                asg_valid,
    input  logic                asg_ready,
    input  logic                res,
    input  logic                res_valid,
    output logic                busy,
    output logic                done,
    output logic                cex_found,
    output logic [NUM_VARS-1:0] cex_asg,
    output logic [CNT_W-1:0]    n_checked
);

    state_t              r_state;
    state_t              w_next_state;
    logic                w_done_pulse;
    logic [NUM_VARS-1:0] r_cur;
    logic [CNT_W-1:0]    r_limit;
    logic                r_stop;
    logic                r_cex_found;
    logic [NUM_VARS-1:0] r_cex_asg;
    logic [CNT_W-1:0]    r_n_checked;
    logic                r_asg_valid;
    logic                r_busy;
    logic                r_done;

    logic                w_accept_start;
    logic                w_verdict;
    logic [CNT_W:0]      w_cnt_inc;
    logic                w_last;

    assign w_accept_start = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_verdict      = (r_state == S_WAIT) && res_valid;
    assign w_cnt_inc      = {1'b0, r_n_checked} + {{CNT_W{1'b0}}, 1'b1};
    // The run ends on the verdict that reaches the limit, or on a counterexample when stopping early.
    assign w_last         = w_verdict &&
                            ((w_cnt_inc == {1'b0, r_limit}) || (!res && r_stop));

    // Next-state decode and done-pulse request.
    always_comb begin
        w_next_state = r_state;
        w_done_pulse = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept_start) begin
                    if (limit == {CNT_W{1'b0}}) begin
                        w_next_state = S_DONE;
                        w_done_pulse = 1'b1;
                    end else begin
                        w_next_state = S_DRIVE;
                    end
                end else begin
                    w_next_state = r_state;
                end
            end
            S_DRIVE: begin
                if (r_asg_valid && asg_ready) begin
                    w_next_state = S_WAIT;
                end else begin
                    w_next_state = S_DRIVE;
                end
            end
            S_WAIT: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                    w_done_pulse = 1'b1;
                end else if (w_verdict) begin
                    w_next_state = S_DRIVE;
                end else begin
                    w_next_state = S_WAIT;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, run context and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cur       <= {NUM_VARS{1'b0}};
            r_limit     <= {CNT_W{1'b0}};
            r_stop      <= 1'b0;
            r_cex_found <= 1'b0;
            r_cex_asg   <= {NUM_VARS{1'b0}};
            r_n_checked <= {CNT_W{1'b0}};
            r_asg_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_asg_valid <= (w_next_state == S_DRIVE);
            r_busy      <= (w_next_state == S_DRIVE) || (w_next_state == S_WAIT);
            r_done      <= w_done_pulse;
            if (w_accept_start) begin
                r_cur       <= base;
                r_limit     <= limit;
                r_stop      <= stop_on_cex;
                r_cex_found <= 1'b0;
                r_cex_asg   <= {NUM_VARS{1'b0}};
                r_n_checked <= {CNT_W{1'b0}};
            end else if (w_verdict) begin
                if (!(&r_n_checked)) begin
                    r_n_checked <= w_cnt_inc[CNT_W-1:0];
                end
                if (!res && !r_cex_found) begin
                    r_cex_found <= 1'b1;
                    r_cex_asg   <= r_cur;
                end
                // Wraps silently past all-ones.
                if (!w_last) begin
                    r_cur <= r_cur + {{(NUM_VARS-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign asg       = r_cur;
    assign asg_valid = r_asg_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cex_found = r_cex_found;
    assign cex_asg   = r_cex_asg;
    assign n_checked = r_n_checked;

endmodule

// File: tb/tb_assign_enum_driver.sv
// Scoreboard bench: expected assignments are queued at start, popped on each handshake;
// a behavioural evaluator answers one cycle after acceptance.
module tb_assign_enum_driver;

    localparam int NV = 49;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NV-1:0] base;
    logic [CW-1:0] limit;
    logic          stop_on_cex;
    logic [NV-1:0] asg;
    logic          asg_valid;
    logic          asg_ready;
    logic          res;
    logic          res_valid;
    logic          busy;
    logic          done;
    logic          cex_found;
    logic [NV-1:0] cex_asg;
    logic [CW-1:0] n_checked;

    int n_checks = 0;
    int n_pass   = 0;

    logic [NV-1:0] sb_q[$];
    logic          eval_mute = 1'b0;
    logic          cex_en    = 1'b0;
    logic [NV-1:0] cex_val   = {NV{1'b0}};
    logic          pend      = 1'b0;
    logic [NV-1:0] pend_asg  = {NV{1'b0}};
    int            n_verdicts = 0;

    assign_enum_driver #(.NUM_VARS(NV), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base), .limit(limit),
        .stop_on_cex(stop_on_cex), .asg(asg), .asg_valid(asg_valid),
        .asg_ready(asg_ready), .res(res), .res_valid(res_valid), .busy(busy),
        .done(done), .cex_found(cex_found), .cex_asg(cex_asg), .n_checked(n_checked)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Evaluator: answers the previously accepted assignment, and scores each new handshake.
    initial begin
        res_valid = 1'b0;
        res       = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (!eval_mute) begin
                if (pend) begin
                    res_valid = 1'b1;
                    res       = cex_en ? (pend_asg != cex_val) : 1'b1;
                    n_verdicts++;
                end else begin
                    res_valid = 1'b0;
                end
            end
            pend = 1'b0;
            if (!rst && asg_valid && asg_ready) begin
                pend     = 1'b1;
                pend_asg = asg;
                check_val("sb_nonempty", {63'd0, sb_q.size() > 0}, 64'd1);
                if (sb_q.size() > 0) check_val("asg_seq", {15'd0, asg}, {15'd0, sb_q.pop_front()});
            end
        end
    end

    task automatic wait_done(input logic poke, input logic [NV-1:0] pb, output int cyc, output logic got);
        cyc = 0;
        got = 1'b0;
        while (cyc < 400 && !got) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done) got = 1'b1;
            else if (poke && cyc == 3) begin
                base  = pb;
                limit = 32'd1;
                start = 1'b1;
            end
        end
        start = 1'b0;
    endtask

    task automatic run(input logic [NV-1:0] b, input logic [CW-1:0] lim, input logic stp,
                       input logic cen, input logic [NV-1:0] cv, input logic poke, output int cyc);
        logic [NV-1:0] a;
        int            en;
        logic          ef;
        logic [NV-1:0] ea;
        logic          got;
        en = 0; ef = 1'b0; ea = {NV{1'b0}}; a = b;
        for (int i = 0; i < int'(lim); i++) begin
            sb_q.push_back(a);
            en++;
            if (cen && a == cv) begin
                if (!ef) begin ef = 1'b1; ea = a; end
                if (stp) break;
            end
            a = a + {{(NV-1){1'b0}}, 1'b1};
        end
        cex_en  = cen;
        cex_val = cv;
        n_verdicts = 0;
        @(negedge clk);
        base = b; limit = lim; stop_on_cex = stp; start = 1'b1;
        wait_done(poke, ~b, cyc, got);
        check_val("done_seen", {63'd0, got}, 64'd1);
        check_val("n_checked", {32'd0, n_checked}, en);
        check_val("verdicts", n_verdicts, en);
        check_val("cex_found", {63'd0, cex_found}, {63'd0, ef});
        if (ef) check_val("cex_asg", {15'd0, cex_asg}, {15'd0, ea});
        check_val("sb_drained", sb_q.size(), 64'd0);
        check_val("busy_done", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check_val("done_pulse_1cyc", {63'd0, done}, 64'd0);
    endtask

    initial begin
        int  cyc;
        logic got;
        rst = 1'b1; start = 1'b0; base = {NV{1'b0}}; limit = 32'd0;
        stop_on_cex = 1'b0; asg_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_busy", {63'd0, busy}, 64'd0);
        check_val("rst_valid", {63'd0, asg_valid}, 64'd0);
        check_val("rst_done", {63'd0, done}, 64'd0);
        check_val("rst_n", {32'd0, n_checked}, 64'd0);
        check_val("rst_asg", {15'd0, asg}, 64'd0);

        run(49'd0, 32'd4, 1'b0, 1'b0, 49'd0, 1'b0, cyc);
        check_val("latency_lim4", cyc, 64'd9);
        run(49'd5, 32'd10, 1'b1, 1'b1, 49'd7, 1'b0, cyc);
        run(49'd5, 32'd10, 1'b0, 1'b1, 49'd7, 1'b1, cyc);
        run({NV{1'b1}}, 32'd2, 1'b0, 1'b0, 49'd0, 1'b0, cyc);

        // Evaluator stalls acceptance for five cycles.
        sb_q.push_back(49'd20);
        sb_q.push_back(49'd21);
        cex_en = 1'b0;
        base = 49'd20; limit = 32'd2; stop_on_cex = 1'b0; asg_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("stall_valid", {63'd0, asg_valid}, 64'd1);
            check_val("stall_asg", {15'd0, asg}, 64'd20);
            check_val("stall_n", {32'd0, n_checked}, 64'd0);
        end
        asg_ready = 1'b1;
        wait_done(1'b0, {NV{1'b0}}, cyc, got);
        check_val("stall_done", {63'd0, got}, 64'd1);
        check_val("stall_n_end", {32'd0, n_checked}, 64'd2);

        // Reset while waiting for a verdict.
        eval_mute = 1'b1;
        sb_q.push_back(49'd9);
        @(negedge clk);
        base = 49'd9; limit = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check_val("wait_busy", {63'd0, busy}, 64'd1);
        check_val("wait_valid", {63'd0, asg_valid}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_busy", {63'd0, busy}, 64'd0);
        check_val("midrst_valid", {63'd0, asg_valid}, 64'd0);
        check_val("midrst_asg", {15'd0, asg}, 64'd0);
        check_val("midrst_n", {32'd0, n_checked}, 64'd0);
        check_val("midrst_cex", {63'd0, cex_found}, 64'd0);
        res_valid = 1'b1; res = 1'b0;
        @(negedge clk);
        res_valid = 1'b0; res = 1'b1;
        @(negedge clk);
        check_val("stray_res_n", {32'd0, n_checked}, 64'd0);
        check_val("stray_res_cex", {63'd0, cex_found}, 64'd0);
        check_val("stray_res_busy", {63'd0, busy}, 64'd0);
        eval_mute = 1'b0;
        run(49'd3, 32'd0, 1'b0, 1'b0, 49'd0, 1'b0, cyc);
        check_val("latency_lim0", cyc, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
